// File: rtl/instr_loader_pkg.sv
// Shared state encoding, defaults and helpers for the instruction loader.
// Defining LOADER_CHECKSUM_EN adds the CHK state for a trailing XOR checksum byte.
package instr_loader_pkg;

  localparam int unsigned LenW            = 16;
  localparam logic [31:0] DefaultBaseAddr = 32'h0000_1000;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StLenLo = 3'd1;
  localparam state_t StLenHi = 3'd2;
  localparam state_t StData  = 3'd3;
  localparam state_t StWrite = 3'd4;
  localparam state_t StDone  = 3'd5;
  localparam state_t StErr   = 3'd6;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t StChk   = 3'd7;
`endif

  // True while a load is in flight (CPU must stay held).
  function automatic logic state_busy(state_t s);
    return !((s == StIdle) || (s == StDone) || (s == StErr));
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: keeps the three previous bytes and
// pulses word_valid in the cycle the fourth byte of a word is presented.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] sr_q, sr_d;
  logic [1:0]  cnt_q, cnt_d;

  assign word       = {byte_in, sr_q};
  assign word_valid = byte_en && (cnt_q == 2'd3);

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (byte_en) begin
      sr_d  = {byte_in, sr_q[23:8]};
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Streams a length-prefixed little-endian byte image into instruction memory
// while holding the CPU in reset. Optional checksum via LOADER_CHECKSUM_EN.
module instr_loader import instr_loader_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = DefaultBaseAddr,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  state_t            state_q, state_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [LenW-1:0]   word_idx_q, word_idx_d;
  logic [LenW-1:0]   len_full;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q;
  logic              accept;
  logic              start_load;
  logic              pack_en;
  logic [31:0]       word;
  logic              word_valid;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  // State reached once all words are written (or for an empty image).
`ifdef LOADER_CHECKSUM_EN
  localparam state_t StTail = StChk;
`else
  localparam state_t StTail = StDone;
`endif

  assign start_load = start && !state_busy(state_q);
  assign accept     = in_valid && in_ready;
  assign pack_en    = accept && (state_q == StData);
  assign len_full   = {in_data, len_q[7:0]};

  byte_packer u_byte_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_load),
    .byte_en    (pack_en),
    .byte_in    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d    = StLenLo;
          len_d      = '0;
          word_idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d   = {{(LenW-8){1'b0}}, in_data};
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == '0) begin
            state_d = StTail;
          end else if (32'(len_full) > MEM_WORDS) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (word_valid) begin
            mem_addr_d  = BASE_ADDR + {{(30-LenW){1'b0}}, word_idx_q, 2'b00};
            mem_wdata_d = word;
            state_d     = StWrite;
          end
        end
      end
      StWrite: begin
        word_idx_d = word_idx_q + 1'b1;
        state_d    = (word_idx_d == len_q) ? StTail : StData;
      end
`ifdef LOADER_CHECKSUM_EN
      StChk: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? StDone : StErr;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      word_idx_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= state_busy(state_d);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

`ifdef LOADER_CHECKSUM_EN
  assign in_ready = (state_q == StLenLo) || (state_q == StLenHi) ||
                    (state_q == StData)  || (state_q == StChk);
`else
  assign in_ready = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
`endif

  assign mem_we    = (state_q == StWrite);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = state_busy(state_q);
  assign cpu_hold  = cpu_hold_q;
  assign done      = (state_q == StDone);
  assign error     = (state_q == StErr);

endmodule
